// File: rtl/mem_responder_if.sv
// Word-wide request/response bus between an initiator and the memory responder.
// The initiator holds req/we/addr/wdata until the one-cycle ready pulse.
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/mem_responder.sv
// Word RAM plus one memory-mapped output register with WAIT_CYCLES wait states;
// one request per WAIT_CYCLES+2 cycles, requests outside IDLE are ignored (no queueing).
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] IO_ADDR     = 32'hFFFF_FFF0
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    output logic [31:0]     io_out
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] io_q, io_d;

    logic [31:0] mem_q [DEPTH_WORDS];
    logic             mem_we_d;
    logic [IDX_W-1:0] mem_idx_d;
    logic [31:0]      mem_wdata_d;

    logic             x_we;
    logic [31:0]      x_addr;
    logic [31:0]      x_wdata;
    logic             enter_resp;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ready_d     = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        io_d        = io_q;
        mem_we_d    = 1'b0;
        enter_resp  = 1'b0;

        // With zero wait states the access executes on the accepting edge,
        // so it must use the live bus rather than the latched copy.
        if (state_q == ST_IDLE) begin
            x_we    = bus.we;
            x_addr  = bus.addr;
            x_wdata = bus.wdata;
        end else begin
            x_we    = we_q;
            x_addr  = addr_q;
            x_wdata = wdata_q;
        end
        mem_idx_d   = x_addr[IDX_W+1:2];
        mem_wdata_d = x_wdata;

        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (WAIT_CYCLES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            rdata_d = 32'd0;
            if (x_addr[1:0] != 2'b00) begin
                err_d = 1'b1;
            end else if (x_addr == IO_ADDR) begin
                if (x_we) io_d = x_wdata;
                else      rdata_d = io_q;
            end else if ({2'b00, x_addr[31:2]} < DEPTH_WORDS) begin
                if (x_we) mem_we_d = 1'b1;
                else      rdata_d = mem_q[mem_idx_d];
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            io_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            io_q    <= io_d;
        end
    end

    // RAM is never cleared; a reset coinciding with the write edge suppresses the write.
    always_ff @(posedge clk) begin
        if (mem_we_d && !reset) begin
            mem_q[mem_idx_d] <= mem_wdata_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign io_out    = io_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if bus2();
    mem_responder_if bus0();
    logic [31:0] io2;
    logic [31:0] io0;

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .IO_ADDR(32'hFFFF_FFF0)) dut (
        .clk(clk), .reset(reset), .bus(bus2.slave), .io_out(io2)
    );
    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .IO_ADDR(32'hFFFF_FFF0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .io_out(io0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (s) begin
            bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus2.req = r; bus2.we = w; bus2.addr = a; bus2.wdata = d;
        end
    endtask

    // Issues one transaction; lat counts rising edges from request to the first
    // edge after which ready is seen high (20 means it never came).
    task automatic xact(input bit s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
        logic rdy;
        rdy = 1'b0;
        lat = 0;
        @(negedge clk);
        drive(s, 1'b1, w, a, d);
        while (!rdy && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            rdy = s ? bus0.ready : bus2.ready;
        end
        rd = s ? bus0.rdata : bus2.rdata;
        e  = s ? bus0.err   : bus2.err;
        drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check("ready_one_cycle", 32'(s ? bus0.ready : bus2.ready), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          t [3];
        int          np;
        int          stray;

        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        #12;
        check("rst_ready", 32'(bus2.ready), 32'd0);
        check("rst_err",   32'(bus2.err),   32'd0);
        check("rst_rdata", bus2.rdata,      32'd0);
        check("rst_io",    io2,             32'd0);
        @(negedge clk);
        reset = 1'b0;

        xact(0, 1'b1, 32'h08, 32'hDEADBEEF, rd, e, lat);
        check("wr08_lat", 32'(lat), 32'd3);
        check("wr08_err", 32'(e), 32'd0);
        check("wr08_rdata", rd, 32'd0);
        xact(0, 1'b0, 32'h08, 32'd0, rd, e, lat);
        check("rd08_lat", 32'(lat), 32'd3);
        check("rd08_rdata", rd, 32'hDEADBEEF);
        check("rd08_err", 32'(e), 32'd0);

        xact(0, 1'b1, 32'h00, 32'h0BADF00D, rd, e, lat);
        xact(0, 1'b1, 32'hFFFF_FFF0, 32'h0000_00A5, rd, e, lat);
        check("io_wr_err", 32'(e), 32'd0);
        check("io_out", io2, 32'h0000_00A5);
        xact(0, 1'b0, 32'hFFFF_FFF0, 32'd0, rd, e, lat);
        check("io_rd_rdata", rd, 32'h0000_00A5);

        xact(0, 1'b0, 32'h06, 32'd0, rd, e, lat);
        check("misalign_err", 32'(e), 32'd1);
        check("misalign_rdata", rd, 32'd0);
        xact(0, 1'b1, 32'h100, 32'h1234, rd, e, lat);
        check("range_err", 32'(e), 32'd1);
        check("range_rdata", rd, 32'd0);
        xact(0, 1'b0, 32'h00, 32'd0, rd, e, lat);
        check("rd00_unchanged", rd, 32'h0BADF00D);

        xact(0, 1'b1, 32'h10, 32'h11111111, rd, e, lat);

        // req held across three back-to-back writes
        np = 0;
        t[0] = 0; t[1] = 0; t[2] = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h00, 32'hA0);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus2.ready) begin
                if (np < 3) t[np] = c;
                np++;
                if (np == 1)      drive(0, 1'b1, 1'b1, 32'h04, 32'hA1);
                else if (np == 2) drive(0, 1'b1, 1'b1, 32'h0C, 32'hA2);
                else              drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("held_pulses", 32'(np), 32'd3);
        check("held_first", 32'(t[0]), 32'd3);
        check("held_gap1", 32'(t[1] - t[0]), 32'd4);
        check("held_gap2", 32'(t[2] - t[1]), 32'd4);
        xact(0, 1'b0, 32'h00, 32'd0, rd, e, lat);
        check("held_rd00", rd, 32'hA0);
        xact(0, 1'b0, 32'h04, 32'd0, rd, e, lat);
        check("held_rd04", rd, 32'hA1);
        xact(0, 1'b0, 32'h0C, 32'd0, rd, e, lat);
        check("held_rd0C", rd, 32'hA2);

        // reset lands while the write to 0x10 is in WAIT
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h10, 32'h55);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus2.ready) stray++;
        end
        check("rst_abort_noready", 32'(stray), 32'd0);
        check("rst_abort_io", io2, 32'd0);
        xact(0, 1'b0, 32'h10, 32'd0, rd, e, lat);
        check("rst_abort_rd10", rd, 32'h11111111);

        xact(1, 1'b1, 32'h04, 32'hCAFE0001, rd, e, lat);
        check("w0_wr_lat", 32'(lat), 32'd1);
        xact(1, 1'b0, 32'h04, 32'd0, rd, e, lat);
        check("w0_rd_lat", 32'(lat), 32'd1);
        check("w0_rd_rdata", rd, 32'hCAFE0001);
        check("w0_rd_err", 32'(e), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
